// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters, syncs, video_on, frame_tick.
// Optional frame-rate blink source enabled by defining VGA_BLINK_EN; otherwise blink is tied low.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick,
    output logic       blink
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [3:0] div_cnt_reg, div_cnt_next;
    logic       p_tick_reg;
    logic [9:0] h_cnt_reg, h_cnt_next;
    logic [9:0] v_cnt_reg, v_cnt_next;
    logic       hsync_reg, vsync_reg;
    logic       h_end, v_end;

    always_comb begin
        div_cnt_next = (div_cnt_reg == DIV_LAST) ? 4'd0 : div_cnt_reg + 4'd1;
        h_end        = (h_cnt_reg == H_LAST);
        v_end        = (v_cnt_reg == V_LAST);
        h_cnt_next   = h_cnt_reg;
        v_cnt_next   = v_cnt_reg;
        if (p_tick_reg) begin
            h_cnt_next = h_end ? 10'd0 : h_cnt_reg + 10'd1;
            if (h_end)
                v_cnt_next = v_end ? 10'd0 : v_cnt_reg + 10'd1;
        end
    end

    // Syncs are decoded from the next counter values so they switch on the same edge as pix_x/pix_y.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt_reg <= 4'd0;
            p_tick_reg  <= 1'b0;
            h_cnt_reg   <= 10'd0;
            v_cnt_reg   <= 10'd0;
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
        end else begin
            div_cnt_reg <= div_cnt_next;
            p_tick_reg  <= (div_cnt_reg == DIV_LAST);
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            hsync_reg   <= !((h_cnt_next >= HS_START) && (h_cnt_next < HS_END));
            vsync_reg   <= !((v_cnt_next >= VS_START) && (v_cnt_next < VS_END));
        end
    end

    assign p_tick     = p_tick_reg;
    assign pix_x      = h_cnt_reg;
    assign pix_y      = v_cnt_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign video_on   = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    assign frame_tick = p_tick_reg && h_end && v_end;

`ifdef VGA_BLINK_EN
    logic [5:0] frame_cnt_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            frame_cnt_reg <= 6'd0;
        else if (frame_tick)
            frame_cnt_reg <= frame_cnt_reg + 6'd1;
    end

    assign blink = frame_cnt_reg[5];
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen: two scaled-down instances (CLK_DIV=2 and CLK_DIV=1)
// compared every cycle against an arithmetic model of pixel position versus time since reset.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    localparam int HD = 16, HF = 2, HS = 4, HB = 2;
    localparam int VD = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_tick_a, blink_a;
    logic [9:0] pix_x_a, pix_y_a;
    logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_tick_b, blink_b;
    logic [9:0] pix_x_b, pix_y_b;

    int  total_cnt = 0;
    int  bad_cnt   = 0;
    longint n = 0;   // rising edges since RESET was released
    int  ft_seen = 0;

    always #5 CLK = ~CLK;

    vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .p_tick(p_tick_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .frame_tick(frame_tick_a), .blink(blink_a));

    vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .p_tick(p_tick_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .frame_tick(frame_tick_b), .blink(blink_b));

    task automatic check(input string tag, input longint observed, input longint expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("FAIL %s: got %0d, want %0d (n=%0d, t=%0t)", tag, observed, expected, n, $time);
        end
    endtask

    // Model: a pixel step happens on the edge after each p_tick; p_ticks occur at edges D, 2D, ...
    task automatic check_dut(input string nm, input int d, input logic pt, input logic [9:0] x,
                             input logic [9:0] y, input logic hs, input logic vs, input logic vo,
                             input logic ft, input logic bl);
        longint steps, pos, frames;
        int ex, ey;
        logic ept, eft, ebl;
        steps  = (n == 0) ? 0 : (n - 1) / d;
        pos    = steps % (HT * VT);
        frames = steps / (HT * VT);
        ex     = int'(pos % HT);
        ey     = int'(pos / HT);
        ept    = (n > 0) && (n % d == 0);
        eft    = ept && (ex == HT - 1) && (ey == VT - 1);
`ifdef VGA_BLINK_EN
        ebl    = ((frames % 64) >= 32);
`else
        ebl    = 1'b0;
`endif
        check({nm, "_p_tick"}, pt, ept);
        check({nm, "_pix_x"}, x, ex);
        check({nm, "_pix_y"}, y, ey);
        check({nm, "_hsync"}, hs, !(ex >= HD + HF && ex < HD + HF + HS));
        check({nm, "_vsync"}, vs, !(ey >= VD + VF && ey < VD + VF + VS));
        check({nm, "_video_on"}, vo, (ex < HD) && (ey < VD));
        check({nm, "_frame_tick"}, ft, eft);
        check({nm, "_blink"}, bl, ebl);
    endtask

    task automatic check_all();
        check_dut("d2", 2, p_tick_a, pix_x_a, pix_y_a, hsync_a, vsync_a, video_on_a, frame_tick_a, blink_a);
        check_dut("d1", 1, p_tick_b, pix_x_b, pix_y_b, hsync_b, vsync_b, video_on_b, frame_tick_b, blink_b);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            if (!RESET) n++;
            @(negedge CLK);
            if (frame_tick_a) ft_seen++;
            check_all();
        end
    endtask

    // Assert RESET between edges, check the asynchronous effect, hold 3 CLK, release at a falling edge.
    task automatic do_reset();
        @(negedge CLK);
        #($urandom_range(1, 3));
        RESET = 1'b1;
        n = 0;
        #1;
        check_all();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_all();
        RESET = 1'b0;
    endtask

    initial begin
        int len;
        do_reset();
        $display("seg init: reset released, checking first line");
        run(3 * HT);
        for (int seg = 0; seg < 10; seg++) begin
            len = int'($urandom_range(40, 1600));
            run(len);
            $display("seg %0d: ran %0d cycles, d2 at (%0d,%0d), d1 at (%0d,%0d)",
                     seg, len, pix_x_a, pix_y_a, pix_x_b, pix_y_b);
            do_reset();
        end
        ft_seen = 0;
        run(66 * 2 * HT * VT + 10);
        check("d2_frame_count", ft_seen, 66);
        $display("seg long: 66 frames at CLK_DIV=2, blink d2=%0b d1=%0b", blink_a, blink_b);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
